// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared constants for the LFSR generator.
//   - MODE_STEP / MODE_RUN : encoding of the lfsr_gen mode input
//   - TAPS_4 .. TAPS_16    : maximal-length feedback masks for the
//                            shift-right Fibonacci form used by lfsr_gen
//                            (mask bit i set => state[i] feeds the XOR)
//   - presc_width()        : counter width needed to count 0..div-1
package lfsr_pkg;

  localparam logic MODE_STEP = 1'b0;
  localparam logic MODE_RUN  = 1'b1;

  // Mask = low-order terms of a primitive polynomial x^W + ... + 1
  localparam logic [3:0]  TAPS_4  = 4'h3;
  localparam logic [4:0]  TAPS_5  = 5'h05;
  localparam logic [5:0]  TAPS_6  = 6'h03;
  localparam logic [6:0]  TAPS_7  = 7'h03;
  localparam logic [7:0]  TAPS_8  = 8'h1D;
  localparam logic [8:0]  TAPS_9  = 9'h011;
  localparam logic [9:0]  TAPS_10 = 10'h009;
  localparam logic [10:0] TAPS_11 = 11'h005;
  localparam logic [11:0] TAPS_12 = 12'h053;
  localparam logic [12:0] TAPS_13 = 13'h001B;
  localparam logic [13:0] TAPS_14 = 14'h0443;
  localparam logic [14:0] TAPS_15 = 15'h0003;
  localparam logic [15:0] TAPS_16 = 16'h002D;

  function automatic int unsigned presc_width(input int unsigned div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/lfsr_gen_sync_edge.sv
// sync_edge: two-flop synchroniser followed by a rising-edge detector.
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   din  : raw level, asynchronous to clk
//   rise : registered one-cycle pulse for each 0->1 transition of din
// A level first captured by s1 at edge k gives rise high after edge k+2.
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic s1, s2, s3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      s3   <= 1'b0;
      rise <= 1'b0;
    end else begin
      s1   <= din;
      s2   <= s1;
      s3   <= s2;
      rise <= s2 & ~s3;
    end
  end

endmodule

// File: rtl/lfsr_gen.sv
// lfsr_gen: parametrised Fibonacci LFSR pseudo-random generator.
//   clk      : system clock
//   rst      : asynchronous active-high reset
//   mode     : MODE_STEP (button-stepped) or MODE_RUN (prescaled free-run)
//   step     : raw button level, synchronised internally
//   load     : synchronous seed load strobe (beats a same-cycle advance)
//   seed     : value to load; zero is replaced by RESET_SEED
//   state    : current LFSR value
//   advanced : pulse with each advance-driven state change
//   wrapped  : pulse when state returns to the reference value
//   period   : advances counted in the last completed cycle
//   lockup   : pulse when a zero value was replaced by RESET_SEED
module lfsr_gen
  import lfsr_pkg::*;
#(
  parameter int unsigned       WIDTH      = 8,
  parameter logic [WIDTH-1:0]  TAPS       = TAPS_8,
  parameter logic [WIDTH-1:0]  RESET_SEED = 8'h01,
  parameter int unsigned       DIV        = 4,
  parameter int unsigned       PW         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic             step,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] state,
  output logic             advanced,
  output logic             wrapped,
  output logic [PW-1:0]    period,
  output logic             lockup
);

  localparam int unsigned      PSW     = presc_width(DIV);
  localparam logic [PSW-1:0]   PS_LAST = PSW'(DIV - 1);

  logic             rise;
  logic [PSW-1:0]   presc;
  logic [WIDTH-1:0] refv;
  logic [PW-1:0]    cnt;

  logic             fb;
  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] adv_val;
  logic [PW-1:0]    cnt_inc;
  logic             adv;

  sync_edge u_step_edge (
    .clk  (clk),
    .rst  (rst),
    .din  (step),
    .rise (rise)
  );

  always_comb begin
    fb      = ^(state & TAPS);
    nxt     = {fb, state[WIDTH-1:1]};
    adv_val = (nxt == '0) ? RESET_SEED : nxt;
    cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;
    adv     = (mode == MODE_RUN) ? (presc == PS_LAST) : rise;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RESET_SEED;
      refv     <= RESET_SEED;
      presc    <= '0;
      cnt      <= '0;
      period   <= '0;
      advanced <= 1'b0;
      wrapped  <= 1'b0;
      lockup   <= 1'b0;
    end else begin
      advanced <= 1'b0;
      wrapped  <= 1'b0;
      lockup   <= 1'b0;

      if (load || mode == MODE_STEP || presc == PS_LAST)
        presc <= '0;
      else
        presc <= presc + 1'b1;

      if (load) begin
        if (seed == '0) begin
          state  <= RESET_SEED;
          refv   <= RESET_SEED;
          lockup <= 1'b1;
        end else begin
          state  <= seed;
          refv   <= seed;
        end
        cnt <= '0;
      end else if (adv) begin
        state    <= adv_val;
        lockup   <= (nxt == '0);
        advanced <= 1'b1;
        // period includes the advance that closes the cycle
        if (adv_val == refv) begin
          period  <= cnt_inc;
          cnt     <= '0;
          wrapped <= 1'b1;
        end else begin
          cnt     <= cnt_inc;
        end
      end
    end
  end

endmodule

// File: tb/tb_lfsr_gen.sv
module tb_lfsr_gen;

  logic        clk;
  logic        rst;
  logic        mode;
  logic        step;
  logic        load;
  logic [7:0]  seed;
  logic [7:0]  state;
  logic        advanced;
  logic        wrapped;
  logic [15:0] period;
  logic        lockup;

  int checks;
  int failures;

  lfsr_gen #(
    .WIDTH      (8),
    .TAPS       (8'h1D),
    .RESET_SEED (8'h01),
    .DIV        (4),
    .PW         (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .mode     (mode),
    .step     (step),
    .load     (load),
    .seed     (seed),
    .state    (state),
    .advanced (advanced),
    .wrapped  (wrapped),
    .period   (period),
    .lockup   (lockup)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference next value as a bit stream: the new MSB is the XOR of the
  // stream bits at offsets 0,2,3,4 (x^8+x^4+x^3+x^2+1); zero maps to 1.
  function automatic logic [7:0] ref_next(input logic [7:0] v);
    int unsigned ones;
    logic [7:0] r;
    ones = 0;
    if (v[0]) ones++;
    if (v[2]) ones++;
    if (v[3]) ones++;
    if (v[4]) ones++;
    r = (v >> 1) + ((ones % 2) * 128);
    if (r == 0) r = 8'd1;
    return r;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    mode = 1'b0; step = 1'b0; load = 1'b0; seed = 8'h00;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    apply_reset();
    checks++;
    if (state !== 8'h01) begin failures++; $display("FAIL reset_state got=%h exp=01", state); end
    checks++;
    if (period !== 16'd0) begin failures++; $display("FAIL reset_period got=%0d exp=0", period); end
    checks++;
    if ({advanced, wrapped, lockup} !== 3'b000) begin
      failures++; $display("FAIL reset_pulses got=%b exp=000", {advanced, wrapped, lockup});
    end
    // asynchronous reset in the middle of a free run
    mode = 1'b1;
    repeat (6) tick();
    checks++;
    if (state !== 8'h80) begin failures++; $display("FAIL run_before_async got=%h exp=80", state); end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (state !== 8'h01) begin failures++; $display("FAIL async_reset got=%h exp=01", state); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    mode = 1'b0;
  endtask

  task automatic test_step;
    logic [7:0] exp_v [3];
    int adv_cnt;
    exp_v[0] = 8'h80; exp_v[1] = 8'h40; exp_v[2] = 8'h20;
    apply_reset();
    adv_cnt = 0;
    for (int p = 0; p < 3; p++) begin
      step = 1'b1;
      for (int c = 1; c <= 4; c++) begin
        tick();
        if (advanced) adv_cnt++;
        if (c == 4) begin
          checks++;
          if (state !== exp_v[p] || advanced !== 1'b1) begin
            failures++;
            $display("FAIL step_edge%0d got=%h/%b exp=%h/1", p, state, advanced, exp_v[p]);
          end
        end else begin
          checks++;
          if (advanced !== 1'b0) begin
            failures++; $display("FAIL step_early%0d clk%0d got adv=%b exp=0", p, c, advanced);
          end
        end
      end
      step = 1'b0;
      repeat (4) begin
        tick();
        if (advanced) adv_cnt++;
      end
    end
    checks++;
    if (adv_cnt != 3) begin failures++; $display("FAIL step_count got=%0d exp=3", adv_cnt); end
    adv_cnt = 0;
    step = 1'b1;
    repeat (20) begin
      tick();
      if (advanced) adv_cnt++;
    end
    step = 1'b0;
    repeat (4) tick();
    checks++;
    if (adv_cnt != 1 || state !== 8'h10) begin
      failures++; $display("FAIL step_hold got=%0d/%h exp=1/10", adv_cnt, state);
    end
  endtask

  task automatic test_freerun_and_load;
    logic [7:0] first_v [5];
    bit         seen [256];
    logic [7:0] m;
    int wr_cnt;
    first_v[0] = 8'h80; first_v[1] = 8'h40; first_v[2] = 8'h20;
    first_v[3] = 8'h10; first_v[4] = 8'h88;
    for (int i = 0; i < 256; i++) seen[i] = 1'b0;
    apply_reset();
    mode = 1'b1;
    m = 8'h01;
    wr_cnt = 0;
    for (int c = 1; c <= 1020; c++) begin
      tick();
      if (wrapped) wr_cnt++;
      checks++;
      if (advanced !== (c % 4 == 0)) begin
        failures++; $display("FAIL run_adv clk%0d got=%b exp=%b", c, advanced, (c % 4 == 0));
      end
      if (c % 4 == 0) begin
        m = ref_next(m);
        checks++;
        if (state !== m) begin failures++; $display("FAIL run_state clk%0d got=%h exp=%h", c, state, m); end
        if (c <= 20) begin
          checks++;
          if (state !== first_v[c/4 - 1]) begin
            failures++; $display("FAIL run_first clk%0d got=%h exp=%h", c, state, first_v[c/4 - 1]);
          end
        end
        if (c < 1020) begin
          checks++;
          if (state === 8'h00 || state === 8'h01 || seen[state]) begin
            failures++; $display("FAIL run_distinct clk%0d got=%h exp=new nonzero", c, state);
          end
          seen[state] = 1'b1;
        end
      end
    end
    checks++;
    if (state !== 8'h01 || wrapped !== 1'b1 || period !== 16'd255 || wr_cnt != 1) begin
      failures++;
      $display("FAIL run_wrap got=%h/%b/%0d/%0d exp=01/1/255/1", state, wrapped, period, wr_cnt);
    end

    // zero seed is replaced and flagged
    load = 1'b1; seed = 8'h00;
    tick();
    load = 1'b0;
    checks++;
    if (state !== 8'h01 || lockup !== 1'b1 || advanced !== 1'b0 || period !== 16'd255) begin
      failures++;
      $display("FAIL load_zero got=%h/%b/%b/%0d exp=01/1/0/255", state, lockup, advanced, period);
    end
    repeat (3) tick();
    // load coincides with a free-run advance
    load = 1'b1; seed = 8'hA5;
    tick();
    load = 1'b0;
    checks++;
    if (state !== 8'hA5 || advanced !== 1'b0) begin
      failures++; $display("FAIL load_collide got=%h/%b exp=a5/0", state, advanced);
    end
    repeat (3) tick();
    tick();
    checks++;
    if (state !== 8'h52 || advanced !== 1'b1) begin
      failures++; $display("FAIL load_next got=%h/%b exp=52/1", state, advanced);
    end
    wr_cnt = 0;
    for (int c = 1; c <= 254 * 4; c++) begin
      tick();
      if (wrapped) wr_cnt++;
    end
    checks++;
    if (state !== 8'hA5 || wrapped !== 1'b1 || wr_cnt != 1 || period !== 16'd255) begin
      failures++;
      $display("FAIL load_wrap got=%h/%b/%0d/%0d exp=a5/1/1/255", state, wrapped, wr_cnt, period);
    end
  endtask

  task automatic test_mode_switch;
    apply_reset();
    repeat (2) tick();
    mode = 1'b1; tick();
    mode = 1'b0; tick();
    tick();
    checks++;
    if (state !== 8'h01 || advanced !== 1'b0) begin
      failures++; $display("FAIL mode_toggle got=%h/%b exp=01/0", state, advanced);
    end
    mode = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      checks++;
      if (advanced !== (c == 4)) begin
        failures++; $display("FAIL mode_restart clk%0d got=%b exp=%b", c, advanced, (c == 4));
      end
    end
    checks++;
    if (state !== 8'h80) begin failures++; $display("FAIL mode_restart_state got=%h exp=80", state); end
    mode = 1'b0;
  endtask

  task automatic test_random;
    logic [7:0]  m_state, m_ref, v;
    logic [15:0] m_cnt, m_per;
    int          m_p;
    logic        h1, h2, h3, h4, rise, go;
    logic        e_adv, e_wr, e_lk;
    apply_reset();
    m_state = 8'h01; m_ref = 8'h01; m_cnt = 0; m_per = 0; m_p = 0;
    h1 = 0; h2 = 0; h3 = 0; h4 = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(0, 99) < 3) mode = ~mode;
      if ($urandom_range(0, 5) == 0) step = ~step;
      load = ($urandom_range(0, 59) == 0);
      seed = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      // step sampled at edge t is acted on at edge t+3 if it was a new high
      rise = h3 & ~h4;
      h4 = h3; h3 = h2; h2 = h1; h1 = step;
      e_adv = 0; e_wr = 0; e_lk = 0;
      if (load) begin
        v = (seed == 0) ? 8'h01 : seed;
        e_lk = (seed == 0);
        m_state = v; m_ref = v; m_cnt = 0; m_p = 0;
      end else begin
        go = mode ? (m_p == 3) : rise;
        m_p = (mode && m_p != 3) ? m_p + 1 : 0;
        if (go) begin
          m_state = ref_next(m_state);
          e_adv = 1;
          if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 1;
          if (m_state == m_ref) begin
            m_per = m_cnt; m_cnt = 0; e_wr = 1;
          end
        end
      end
      tick();
      checks++;
      if (state !== m_state || advanced !== e_adv || wrapped !== e_wr ||
          lockup !== e_lk || period !== m_per) begin
        failures++;
        $display("FAIL random cyc%0d got=%h/%b/%b/%b/%0d exp=%h/%b/%b/%b/%0d", cyc,
                 state, advanced, wrapped, lockup, period,
                 m_state, e_adv, e_wr, e_lk, m_per);
      end
    end
    load = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b0; mode = 1'b0; step = 1'b0; load = 1'b0; seed = 8'h00;
    test_reset();
    test_step();
    test_freerun_and_load();
    test_mode_switch();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
